// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
//   Time-multiplexed driver for an N-digit 7-segment display. A packed hex word
//   is captured on a load strobe, held in a shadow register, and committed to
//   the displayed (active) register only when the scan wraps from the last
//   digit back to digit 0, so a frame is never drawn from two different words.
//   Each digit stays selected for REFRESH_DIV clock cycles. Blanked digits keep
//   their time slot, but their anode stays inactive and seg/dp stay off.
//
// Parameters
//   N_DIGITS     number of digits (>=1); digit 0 = rightmost = data_in[3:0]
//   REFRESH_DIV  clock cycles per digit slot (>=2)
//   SEG_ACT_LOW  1: seg/dp driven low = lit, 0: high = lit
//   AN_ACT_LOW   1: an driven low = selected, 0: high = selected
//   LZ_BLANK     1: suppress leading zero digits (digit 0 always shown)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   load        1-cycle strobe capturing data_in/dp_in/blank_in
//   data_in     packed nibbles, digit i = data_in[4i+3:4i]
//   dp_in       decimal point per digit, 1 = lit
//   blank_in    1 = force digit dark
//   seg         {a,b,c,d,e,f,g}, seg[6] = a, pin polarity per SEG_ACT_LOW
//   dp          decimal point of current digit, pin polarity per SEG_ACT_LOW
//   an          one-hot digit select, pin polarity per AN_ACT_LOW
//   frame_done  1-cycle pulse on the cycle after the scan wraps to digit 0
// -----------------------------------------------------------------------------
module sseg_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1,
    parameter int LZ_BLANK    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   data_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Pin levels for "everything dark", used while in reset.
    localparam logic [6:0]          SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_OFF  = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    // ------------------------------------------------------------------
    // Helper functions (all internal logic is active-high)
    // ------------------------------------------------------------------

    // Hex nibble to segments {a,b,c,d,e,f,g}, 1 = lit.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            4'hF:    s = 7'b1000111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Digits suppressed as leading zeros: scanning from the top digit down,
    // every zero digit is suppressed until the first nonzero one. Digit 0 is
    // never part of the mask.
    function automatic logic [N_DIGITS-1:0] lz_mask(input logic [4*N_DIGITS-1:0] d);
        logic [N_DIGITS-1:0] m;
        logic                run;
        m   = {N_DIGITS{1'b0}};
        run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (run && (d[4*i +: 4] == 4'h0)) begin
                m[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
        return m;
    endfunction

    function automatic logic [6:0] seg_pins(input logic [6:0] lit);
        return (SEG_ACT_LOW != 0) ? ~lit : lit;
    endfunction

    function automatic logic dp_pin(input logic lit);
        return (SEG_ACT_LOW != 0) ? ~lit : lit;
    endfunction

    function automatic logic [N_DIGITS-1:0] an_pins(input logic [N_DIGITS-1:0] sel);
        return (AN_ACT_LOW != 0) ? ~sel : sel;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]       div_cnt_r;
    logic [IDX_W-1:0]       idx_r;
    logic [4*N_DIGITS-1:0]  shadow_data_r;
    logic [N_DIGITS-1:0]    shadow_dp_r;
    logic [N_DIGITS-1:0]    shadow_blank_r;
    logic                   pending_r;
    logic [4*N_DIGITS-1:0]  active_data_r;
    logic [N_DIGITS-1:0]    active_dp_r;
    logic [N_DIGITS-1:0]    active_blank_r;
    logic [6:0]             seg_r;
    logic                   dp_r;
    logic [N_DIGITS-1:0]    an_r;
    logic                   frame_done_r;

    logic                   term_s;
    logic                   wrap_s;
    logic [IDX_W-1:0]       idx_next_s;
    logic [N_DIGITS-1:0]    lz_s;
    logic [3:0]             cur_nib_s;
    logic                   cur_dp_s;
    logic                   cur_blank_s;
    logic [N_DIGITS-1:0]    cur_sel_s;
    logic [6:0]             seg_lit_s;
    logic                   dp_lit_s;
    logic [N_DIGITS-1:0]    an_lit_s;

    // Slot timing: terminal count of the divider and the frame wrap edge.
    always_comb begin
        term_s     = (div_cnt_r == DIV_LAST);
        wrap_s     = term_s && (idx_r == IDX_LAST);
        idx_next_s = idx_r;
        if (term_s) begin
            if (idx_r == IDX_LAST) begin
                idx_next_s = {IDX_W{1'b0}};
            end else begin
                idx_next_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            idx_next_s = idx_r;
        end
    end

    // Leading-zero suppression mask, computed from the displayed word.
    always_comb begin
        lz_s = {N_DIGITS{1'b0}};
        if (LZ_BLANK != 0) begin
            lz_s = lz_mask(active_data_r);
        end else begin
            lz_s = {N_DIGITS{1'b0}};
        end
    end

    // Select the nibble, dp and blank state of the digit currently scanned.
    always_comb begin
        cur_nib_s   = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b0;
        cur_sel_s   = {N_DIGITS{1'b0}};
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                cur_nib_s    = active_data_r[4*i +: 4];
                cur_dp_s     = active_dp_r[i];
                cur_blank_s  = active_blank_r[i] | lz_s[i];
                cur_sel_s[i] = 1'b1;
            end else begin
                cur_sel_s[i] = 1'b0;
            end
        end
    end

    // Active-high lit pattern for the current slot; a blanked digit keeps its
    // slot but shows nothing and leaves its anode off.
    always_comb begin
        seg_lit_s = 7'h00;
        dp_lit_s  = 1'b0;
        an_lit_s  = {N_DIGITS{1'b0}};
        if (cur_blank_s) begin
            seg_lit_s = 7'h00;
            dp_lit_s  = 1'b0;
            an_lit_s  = {N_DIGITS{1'b0}};
        end else begin
            seg_lit_s = decode_hex(cur_nib_s);
            dp_lit_s  = cur_dp_s;
            an_lit_s  = cur_sel_s;
        end
    end

    // Divider and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r <= {DIV_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
        end else begin
            div_cnt_r <= term_s ? {DIV_W{1'b0}} : div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
            idx_r     <= idx_next_s;
        end
    end

    // Shadow capture and frame-boundary commit. A load on the wrap cycle goes
    // straight to the active register so it is shown in the frame starting now.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_data_r  <= {(4*N_DIGITS){1'b0}};
            shadow_dp_r    <= {N_DIGITS{1'b0}};
            shadow_blank_r <= {N_DIGITS{1'b0}};
            pending_r      <= 1'b0;
            active_data_r  <= {(4*N_DIGITS){1'b0}};
            active_dp_r    <= {N_DIGITS{1'b0}};
            active_blank_r <= {N_DIGITS{1'b0}};
        end else begin
            if (load) begin
                shadow_data_r  <= data_in;
                shadow_dp_r    <= dp_in;
                shadow_blank_r <= blank_in;
            end
            if (wrap_s) begin
                if (load) begin
                    active_data_r  <= data_in;
                    active_dp_r    <= dp_in;
                    active_blank_r <= blank_in;
                end else if (pending_r) begin
                    active_data_r  <= shadow_data_r;
                    active_dp_r    <= shadow_dp_r;
                    active_blank_r <= shadow_blank_r;
                end
                pending_r <= 1'b0;
            end else if (load) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Registered pin drivers with final polarity applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_r        <= SEG_OFF;
            dp_r         <= DP_OFF;
            an_r         <= AN_OFF;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_pins(seg_lit_s);
            dp_r         <= dp_pin(dp_lit_s);
            an_r         <= an_pins(an_lit_s);
            frame_done_r <= wrap_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_driver
//   Two instances (LZ_BLANK=0 and LZ_BLANK=1, N_DIGITS=4, REFRESH_DIV=4,
//   active-low pins) share one stimulus. A cycle-count model derives the
//   scanned digit arithmetically from time since reset release and predicts
//   every pin each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_sseg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(.N_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACT_LOW(1), .AN_ACT_LOW(1), .LZ_BLANK(0)) u_dut (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
        .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0)
    );

    sseg_scan_driver #(.N_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACT_LOW(1), .AN_ACT_LOW(1), .LZ_BLANK(1)) u_dut_lz (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
        .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1)
    );

    // Segment patterns a..g, 1 = lit, straight from the hex glyph table.
    logic [6:0] seg_tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Expected active-low pins {an[3:0], seg[6:0], dp} while digit dig is scanned.
    function automatic logic [11:0] expect_pins(input logic [15:0] d, input logic [3:0] dpv,
                                                input logic [3:0] bl, input int dig, input bit lz);
        logic       blanked;
        logic [6:0] lit;
        logic [3:0] sel;
        blanked = bl[dig] || (lz && dig > 0 && ((d >> (4 * dig)) == 16'h0000));
        lit     = blanked ? 7'h00 : seg_tbl[d[4*dig +: 4]];
        sel     = blanked ? 4'h0 : 4'(1 << dig);
        return {~sel, ~lit, ~(dpv[dig] & ~blanked)};
    endfunction

    // Model state: cycles since reset release, shadow/active words, expected pins.
    int          m_cyc = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_sh_d, m_act_d;
    logic [3:0]  m_sh_dp, m_sh_bl, m_act_dp, m_act_bl;
    bit          m_pend;
    logic [11:0] exp0, exp1;
    logic        exp_fd;

    // Model: before edge k (k counted from release) the scan shows digit (k/RD)%ND;
    // the edge with k%FRAME == FRAME-1 ends a frame and commits new data.
    always @(posedge clk) begin
        if (reset) begin
            m_valid  <= 1'b1;
            m_cyc    <= 0;
            m_sh_d   <= 16'h0000; m_sh_dp  <= 4'h0; m_sh_bl  <= 4'h0;
            m_act_d  <= 16'h0000; m_act_dp <= 4'h0; m_act_bl <= 4'h0;
            m_pend   <= 1'b0;
            exp0     <= 12'hFFF;
            exp1     <= 12'hFFF;
            exp_fd   <= 1'b0;
        end else begin
            exp0   <= expect_pins(m_act_d, m_act_dp, m_act_bl, (m_cyc / RD) % ND, 1'b0);
            exp1   <= expect_pins(m_act_d, m_act_dp, m_act_bl, (m_cyc / RD) % ND, 1'b1);
            exp_fd <= ((m_cyc % FRAME) == FRAME - 1);
            if ((m_cyc % FRAME) == FRAME - 1) begin
                if (load) begin
                    m_act_d <= data_in; m_act_dp <= dp_in; m_act_bl <= blank_in;
                end else if (m_pend) begin
                    m_act_d <= m_sh_d; m_act_dp <= m_sh_dp; m_act_bl <= m_sh_bl;
                end
                m_pend <= 1'b0;
            end else if (load) begin
                m_sh_d <= data_in; m_sh_dp <= dp_in; m_sh_bl <= blank_in;
                m_pend <= 1'b1;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, m_cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("an",     {28'h0, an0},  {28'h0, exp0[11:8]});
            check("seg",    {25'h0, seg0}, {25'h0, exp0[7:1]});
            check("dp",     {31'h0, dp0},  {31'h0, exp0[0]});
            check("fd",     {31'h0, fd0},  {31'h0, exp_fd});
            check("lz an",  {28'h0, an1},  {28'h0, exp1[11:8]});
            check("lz seg", {25'h0, seg1}, {25'h0, exp1[7:1]});
            check("lz dp",  {31'h0, dp1},  {31'h0, exp1[0]});
            check("lz fd",  {31'h0, fd1},  {31'h0, exp_fd});
        end
    end

    // Advance to the falling edge where the model has counted c cycles.
    task automatic goto(input int c);
        int guard;
        guard = 0;
        while (m_cyc != c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (m_cyc != c) begin
            n_chk++;
            n_err++;
            $display("FAIL goto: at cycle %0d, want %0d", m_cyc, c);
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
        data_in  = d;
        dp_in    = dpv;
        blank_in = bl;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst an",  {28'h0, an0},  32'hF);
        check("rst seg", {25'h0, seg0}, 32'h7F);
        check("rst dp",  {31'h0, dp0},  32'h1);
        check("rst fd",  {31'h0, fd0},  32'h0);
        reset = 1'b0;

        // 1: digit 0 lit with "0" on the second cycle, 4 cycles per digit
        goto(1);
        check("t1 an d0",  {28'h0, an0},  32'b1110);
        check("t1 seg d0", {25'h0, seg0}, 32'b0000001);
        goto(5);
        check("t1 an d1",  {28'h0, an0},  32'b1101);
        goto(16);
        check("t1 fd",     {31'h0, fd0},  32'h1);
        goto(17);
        check("t1 fd low", {31'h0, fd0},  32'h0);

        // 2: mid-frame load waits for the wrap
        goto(20);
        pulse_load(16'h9A3F, 4'h0, 4'h0);
        goto(25);
        check("t2 hold", {25'h0, seg0}, 32'b0000001);
        goto(33);
        check("t2 d0 F", {25'h0, seg0}, 32'b0111000);
        goto(37);
        check("t2 d1 3", {25'h0, seg0}, 32'b0000110);
        goto(41);
        check("t2 d2 A", {25'h0, seg0}, 32'b0001000);
        goto(45);
        check("t2 d3 9", {25'h0, seg0}, 32'b0000100);

        // 3: two loads in one frame, last one wins
        goto(50);
        pulse_load(16'h1111, 4'h0, 4'h0);
        goto(55);
        pulse_load(16'h2222, 4'h0, 4'h0);
        goto(62);
        check("t3 old d3", {25'h0, seg0}, 32'b0000100);
        goto(65);
        check("t3 d0 2",   {25'h0, seg0}, 32'b0010010);

        // 4/5: load on the wrap cycle, leading-zero suppression
        goto(79);
        pulse_load(16'h0050, 4'h0, 4'h0);
        check("t4 fd",        {31'h0, fd0},  32'h1);
        goto(81);
        check("t4 d0 0",      {25'h0, seg0}, 32'b0000001);
        check("t4 an d0",     {28'h0, an0},  32'b1110);
        goto(85);
        check("t5 d1 5",      {25'h0, seg0}, 32'b0100100);
        check("t5 lz d1 5",   {25'h0, seg1}, 32'b0100100);
        goto(89);
        check("t5 lz d2 an",  {28'h0, an1},  32'b1111);
        check("t5 lz d2 seg", {25'h0, seg1}, 32'b1111111);
        check("t5 d2 an",     {28'h0, an0},  32'b1011);
        goto(93);
        check("t5 lz d3 an",  {28'h0, an1},  32'b1111);
        goto(95);
        pulse_load(16'h0000, 4'h0, 4'h0);
        goto(97);
        check("t5 lz0 d0 an",  {28'h0, an1},  32'b1110);
        check("t5 lz0 d0 seg", {25'h0, seg1}, 32'b0000001);
        goto(101);
        check("t5 lz0 d1 an",  {28'h0, an1},  32'b1111);

        // 6: blanking and dp, then reset mid-scan discarding pending data
        goto(111);
        pulse_load(16'h1234, 4'b0110, 4'b0100);
        goto(117);
        check("t6 d1 an",  {28'h0, an0},  32'b1101);
        check("t6 d1 seg", {25'h0, seg0}, 32'b0000110);
        check("t6 d1 dp",  {31'h0, dp0},  32'h0);
        goto(121);
        check("t6 d2 an",  {28'h0, an0},  32'b1111);
        check("t6 d2 seg", {25'h0, seg0}, 32'b1111111);
        check("t6 d2 dp",  {31'h0, dp0},  32'h1);
        goto(122);
        pulse_load(16'h8888, 4'h0, 4'h0);
        reset = 1'b1;
        @(negedge clk);
        check("t6 rst an",  {28'h0, an0},  32'b1111);
        check("t6 rst seg", {25'h0, seg0}, 32'b1111111);
        reset = 1'b0;
        @(negedge clk);
        check("t6 restart an",  {28'h0, an0},  32'b1110);
        check("t6 restart seg", {25'h0, seg0}, 32'b0000001);
        goto(17);
        check("t6 no pending",  {25'h0, seg0}, 32'b0000001);
        goto(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
